sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles spent waiting for read data (or for a late return after a timeout).
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port cl_read  input  3  per-client read request; bit0 record, bit1 play, bit2 load.
REQ-005 SHALL have port cl_write  input  3  per-client write request.
REQ-006 SHALL have port cl_addr  input  23 x3  per-client word address, unpacked array [2:0].
REQ-007 SHALL have port cl_writedata  input  16 x3  per-client write data, unpacked array [2:0].
REQ-008 SHALL have port cl_readdata  output  16  shared read-data return to all clients.
REQ-009 SHALL have port cl_finished  output  3  one-hot completion pulse per client.
REQ-010 SHALL have port sdram_addr  output  23  address to SDRAM controller.
REQ-011 SHALL have port sdram_read / sdram_write  output  1 each  command strobes.
REQ-012 SHALL have port sdram_writedata  output  16  write data.
REQ-013 SHALL have port sdram_readdata  input  16  returned data.
REQ-014 SHALL have port sdram_readdatavalid  input  1  qualifies sdram_readdata.
REQ-015 SHALL have port sdram_waitrequest  input  1  controller stall; command held while high.
REQ-016 SHALL have ports busy output 1 (state != IDLE), grant_id output 2 (granted client), err_timeout output 1 (sticky).

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_RD, DONE, RECOVER; all outputs registered.
REQ-018 In IDLE, a client is requesting if cl_read or cl_write bit set; arbitration is round-robin starting at (last_grant+1) mod 3; the winner's addr, writedata and op are latched; then IDLE->ISSUE, last_grant and grant_id updated.
REQ-019 Client asserting both read and write in the same cycle SHALL be served as a write.
REQ-020 ISSUE: drive latched addr/data and exactly one strobe; hold unchanged while sdram_waitrequest=1.
REQ-021 ISSUE with waitrequest=0: write -> DONE; read -> WAIT_RD with timeout counter cleared; strobe deasserted next cycle.
REQ-022 WAIT_RD: on sdram_readdatavalid capture sdram_readdata into cl_readdata, -> DONE.
REQ-023 WAIT_RD: counter increments each cycle; on reaching TIMEOUT without valid, cl_readdata=16'h0000, err_timeout=1, -> DONE with RECOVER flagged.
REQ-024 DONE lasts exactly one cycle, asserts cl_finished[grant_id] only; next state IDLE, or RECOVER if flagged.
REQ-025 RECOVER: wait for one sdram_readdatavalid (discarded) or TIMEOUT cycles, whichever first, then IDLE; no grants issued.
REQ-026 sdram_readdatavalid outside WAIT_RD/RECOVER SHALL be ignored; readdatavalid is never expected in the accept cycle.
REQ-027 cl_readdata SHALL hold its value until the next read completes; write completions leave it unchanged.
REQ-028 Requests deasserted after grant SHALL not abort the transaction; finished still pulses.
REQ-029 Clients drop request on seeing finished; the IDLE cycle after DONE re-samples, so a client still requesting is eligible only after others by round-robin.
REQ-030 Minimum latency: write request in IDLE at cycle N, waitrequest=0 -> strobe at N+1, finished at N+2.

Reset
REQ-031 While i_rst=1 at a clock edge: state=IDLE, strobes=0, sdram_addr=0, sdram_writedata=0, cl_readdata=0, cl_finished=0, busy=0, grant_id=0, last_grant=2, counter=0, err_timeout=0; reset mid-transaction abandons it with no finished pulse.

Verification
REQ-032 Single write: client0 write addr 23'h000010 data 16'hBEEF, waitrequest=0 -> sdram_write=1 with that addr/data one cycle, cl_finished=3'b001 two cycles after request.
REQ-033 Stalled read: client1 read addr 23'h7FFFFF, waitrequest high 4 cycles, readdatavalid 3 cycles after accept with 16'h1234 -> strobe held 5 cycles, cl_readdata=16'h1234 with cl_finished=3'b010.
REQ-034 Contention: all three request continuously from reset -> grants 0,1,2,0,1,2 in order, one finished pulse per transaction.
REQ-035 Timeout: TIMEOUT=8, read never returns -> finished after 8 WAIT_RD cycles, cl_readdata=0, err_timeout=1, busy through RECOVER, next grant only after 8 more cycles.
REQ-036 Read+write same cycle on client2 -> write performed; i_rst asserted during WAIT_RD -> all outputs at reset values next cycle, no finished.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Three-client round-robin arbiter in front of an Avalon-style SDRAM controller port.
// One transaction in flight at a time; a read that never returns is timed out and drained.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  cl_read,
  input  logic [2:0]  cl_write,
  input  logic [22:0] cl_addr      [2:0],
  input  logic [15:0] cl_writedata [2:0],
  output logic [15:0] cl_readdata,
  output logic [2:0]  cl_finished,
  output logic [22:0] sdram_addr,
  output logic        sdram_read,
  output logic        sdram_write,
  output logic [15:0] sdram_writedata,
  input  logic [15:0] sdram_readdata,
  input  logic        sdram_readdatavalid,
  input  logic        sdram_waitrequest,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StDone,
    StRecover
  } state_e;

  state_e        state;
  logic [1:0]    last_grant;
  logic [CW-1:0] cnt;
  logic          recover_flag;

  logic [2:0] req;
  logic [1:0] c0, c1, c2;
  logic [1:0] winner;

  // Priority order starts just after the previous winner.
  always_comb begin
    req = cl_read | cl_write;
    case (last_grant)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (req[c0])      winner = c0;
    else if (req[c1]) winner = c1;
    else              winner = c2;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= StIdle;
      last_grant      <= 2'd2;
      cnt             <= '0;
      recover_flag    <= 1'b0;
      cl_readdata     <= 16'h0000;
      cl_finished     <= 3'b000;
      sdram_addr      <= 23'h0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_writedata <= 16'h0000;
      busy            <= 1'b0;
      grant_id        <= 2'd0;
      err_timeout     <= 1'b0;
    end else begin
      cl_finished <= 3'b000;
      case (state)
        StIdle: begin
          if (|req) begin
            grant_id        <= winner;
            last_grant      <= winner;
            sdram_addr      <= cl_addr[winner];
            sdram_writedata <= cl_writedata[winner];
            // Write wins when a client raises both strobes.
            sdram_write     <= cl_write[winner];
            sdram_read      <= ~cl_write[winner];
            busy            <= 1'b1;
            state           <= StIssue;
          end
        end
        StIssue: begin
          if (!sdram_waitrequest) begin
            sdram_read  <= 1'b0;
            sdram_write <= 1'b0;
            cnt         <= '0;
            if (sdram_write) begin
              cl_finished <= 3'b001 << grant_id;
              state       <= StDone;
            end else begin
              state <= StWaitRd;
            end
          end
        end
        StWaitRd: begin
          if (sdram_readdatavalid) begin
            cl_readdata <= sdram_readdata;
            cl_finished <= 3'b001 << grant_id;
            state       <= StDone;
          end else if (cnt == LAST) begin
            cl_readdata  <= 16'h0000;
            err_timeout  <= 1'b1;
            recover_flag <= 1'b1;
            cl_finished  <= 3'b001 << grant_id;
            state        <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDone: begin
          cnt          <= '0;
          recover_flag <= 1'b0;
          if (recover_flag) begin
            state <= StRecover;
          end else begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        StRecover: begin
          // Swallow the late return of the timed-out read, if it ever comes.
          if (sdram_readdatavalid || cnt == LAST) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of the arbiter.
module tb_sdram_arbiter;

  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [2:0]  cl_read, cl_write;
  logic [22:0] cl_addr      [2:0];
  logic [15:0] cl_writedata [2:0];
  logic [15:0] cl_readdata;
  logic [2:0]  cl_finished;
  logic [22:0] sdram_addr;
  logic        sdram_read, sdram_write;
  logic [15:0] sdram_writedata;
  logic [15:0] sdram_readdata;
  logic        sdram_readdatavalid, sdram_waitrequest;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_timeout;

  sdram_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .cl_read             (cl_read),
    .cl_write            (cl_write),
    .cl_addr             (cl_addr),
    .cl_writedata        (cl_writedata),
    .cl_readdata         (cl_readdata),
    .cl_finished         (cl_finished),
    .sdram_addr          (sdram_addr),
    .sdram_read          (sdram_read),
    .sdram_write         (sdram_write),
    .sdram_writedata     (sdram_writedata),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .sdram_waitrequest   (sdram_waitrequest),
    .busy                (busy),
    .grant_id            (grant_id),
    .err_timeout         (err_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // ---------------- transaction-level model ----------------
  bit          chk_en = 1'b0;
  logic [15:0] exp_rd;
  logic [2:0]  exp_fin;
  logic        exp_busy, exp_err, exp_rs, exp_ws;
  logic [1:0]  exp_gid;
  logic [22:0] exp_addr;
  logic [15:0] exp_wdata;
  int          m_last, m_client, m_wait, m_rcnt;
  bit          m_active, m_accepted, m_wr, m_to, m_recov;

  task automatic finish_txn();
    exp_fin  = 3'b001 << m_client;
    m_active = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] rq;
    bit         got;
    int         c;
    if (i_rst) begin
      exp_rd = '0; exp_fin = '0; exp_busy = 0; exp_err = 0; exp_rs = 0; exp_ws = 0;
      exp_gid = '0; exp_addr = '0; exp_wdata = '0;
      m_last = 2; m_active = 0; m_accepted = 0; m_to = 0; m_recov = 0;
      chk_en = 1'b1;
    end else if (exp_fin != 3'b000) begin
      exp_fin = 3'b000;
      if (m_to) begin
        m_recov = 1; m_rcnt = 0; m_to = 0;
      end else begin
        exp_busy = 0;
      end
    end else if (m_recov) begin
      if (sdram_readdatavalid || m_rcnt + 1 == TO) begin
        m_recov = 0; exp_busy = 0;
      end else begin
        m_rcnt++;
      end
    end else if (!m_active) begin
      rq  = cl_read | cl_write;
      got = 0;
      c   = 0;
      for (int k = 1; k <= 3; k++) begin
        if (!got && rq[(m_last + k) % 3]) begin
          got = 1;
          c   = (m_last + k) % 3;
        end
      end
      if (got) begin
        m_active = 1; m_accepted = 0; m_client = c; m_last = c;
        m_wr      = cl_write[c];
        exp_gid   = 2'(c);
        exp_busy  = 1;
        exp_addr  = cl_addr[c];
        exp_wdata = cl_writedata[c];
        exp_ws    = m_wr;
        exp_rs    = !m_wr;
      end
    end else if (!m_accepted) begin
      if (!sdram_waitrequest) begin
        exp_ws = 0; exp_rs = 0;
        if (m_wr) finish_txn();
        else begin
          m_accepted = 1; m_wait = 0;
        end
      end
    end else begin
      if (sdram_readdatavalid) begin
        exp_rd = sdram_readdata;
        finish_txn();
      end else if (m_wait + 1 == TO) begin
        exp_rd = 16'h0000; exp_err = 1; m_to = 1;
        finish_txn();
      end else begin
        m_wait++;
      end
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    model_step();
  end

  // Per-cycle compare, away from the active edge.
  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      check("cycle_outputs",
            {cl_readdata, cl_finished, busy, grant_id, err_timeout, sdram_read, sdram_write} ===
            {exp_rd, exp_fin, exp_busy, exp_gid, exp_err, exp_rs, exp_ws},
            64'({cl_readdata, cl_finished, busy, grant_id, err_timeout, sdram_read, sdram_write}),
            64'({exp_rd, exp_fin, exp_busy, exp_gid, exp_err, exp_rs, exp_ws}));
      if (exp_rs || exp_ws)
        check("cycle_addr", sdram_addr === exp_addr, 64'(sdram_addr), 64'(exp_addr));
      if (exp_ws)
        check("cycle_wdata", sdram_writedata === exp_wdata, 64'(sdram_writedata),
              64'(exp_wdata));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic clear_inputs();
    cl_read = '0; cl_write = '0;
    for (int i = 0; i < 3; i++) begin
      cl_addr[i] = '0; cl_writedata[i] = '0;
    end
    sdram_readdata = '0; sdram_readdatavalid = 0; sdram_waitrequest = 0;
  endtask

  int held, n, m, rec_busy, pulses;
  int order [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    clear_inputs();
    i_rst = 1;
    tick(); tick();
    check("rst_values",
          {busy, grant_id, cl_readdata, cl_finished, err_timeout, sdram_read, sdram_write} === '0
          && sdram_addr === '0 && sdram_writedata === '0,
          64'({busy, grant_id, cl_readdata, cl_finished, err_timeout, sdram_read, sdram_write}),
          64'h0);
    i_rst = 0;

    // Single write, minimum latency.
    cl_write = 3'b001; cl_addr[0] = 23'h000010; cl_writedata[0] = 16'hBEEF;
    tick();
    check("wr_strobe", sdram_write === 1'b1 && sdram_read === 1'b0,
          64'({sdram_read, sdram_write}), 64'b01);
    check("wr_addr", sdram_addr === 23'h000010, 64'(sdram_addr), 64'h10);
    check("wr_data", sdram_writedata === 16'hBEEF, 64'(sdram_writedata), 64'hBEEF);
    cl_write = 3'b000;
    tick();
    check("wr_finished", cl_finished === 3'b001 && sdram_write === 1'b0,
          64'({cl_finished, sdram_write}), 64'b0010);
    tick();
    check("wr_idle", busy === 1'b0 && cl_finished === 3'b000, 64'({busy, cl_finished}), 64'h0);

    // Stalled read on client 1.
    cl_read = 3'b010; cl_addr[1] = 23'h7FFFFF; sdram_waitrequest = 1;
    tick();
    cl_read = 3'b000;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (sdram_read === 1'b1 && sdram_addr === 23'h7FFFFF) held++;
      if (i == 4) sdram_waitrequest = 0;
      tick();
    end
    check("rd_strobe_held", held == 5, 64'(held), 64'd5);
    check("rd_strobe_drop", sdram_read === 1'b0 && busy === 1'b1,
          64'({sdram_read, busy}), 64'b01);
    tick(); tick();
    sdram_readdatavalid = 1; sdram_readdata = 16'h1234;
    tick();
    sdram_readdatavalid = 0; sdram_readdata = 16'h0;
    check("rd_data", cl_readdata === 16'h1234 && cl_finished === 3'b010,
          64'({cl_readdata, cl_finished}), 64'({16'h1234, 3'b010}));
    tick();

    // Round-robin contention from reset.
    i_rst = 1; cl_write = 3'b111;
    tick();
    i_rst = 0;
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 6; i++) begin
      tick();
      if (cl_finished !== 3'b000) begin
        check("rr_order", cl_finished === (3'b001 << order[pulses]),
              64'(cl_finished), 64'(3'b001 << order[pulses]));
        pulses++;
        if (pulses == 6) cl_write = 3'b000;
      end
    end
    check("rr_pulses", pulses == 6, 64'(pulses), 64'd6);
    tick();

    // Read that never returns.
    cl_read = 3'b001;
    tick();
    cl_read = 3'b000;
    tick();
    n = 0;
    while (cl_finished === 3'b000 && n < 30) begin
      tick();
      n++;
    end
    check("to_wait_cycles", n == 8, 64'(n), 64'd8);
    check("to_result", cl_finished === 3'b001 && cl_readdata === 16'h0 && err_timeout === 1'b1,
          64'({cl_finished, cl_readdata, err_timeout}), 64'({3'b001, 16'h0, 1'b1}));
    cl_read = 3'b010;
    m = 0; rec_busy = 0;
    while (sdram_read !== 1'b1 && m < 30) begin
      tick();
      m++;
      if (busy === 1'b1 && sdram_read !== 1'b1) rec_busy++;
    end
    check("to_recover_busy", rec_busy == 8, 64'(rec_busy), 64'd8);
    check("to_next_grant", m == 10 && grant_id === 2'd1, 64'({m[7:0], grant_id}),
          64'({8'd10, 2'd1}));
    cl_read = 3'b000;
    tick();
    sdram_readdatavalid = 1; sdram_readdata = 16'h5A5A;
    tick();
    sdram_readdatavalid = 0;
    check("to_sticky", cl_readdata === 16'h5A5A && err_timeout === 1'b1,
          64'({cl_readdata, err_timeout}), 64'({16'h5A5A, 1'b1}));
    tick();

    // Read and write together on client 2: served as a write.
    cl_read = 3'b100; cl_write = 3'b100; cl_addr[2] = 23'h000123; cl_writedata[2] = 16'hCAFE;
    tick();
    check("rw_is_write", sdram_write === 1'b1 && sdram_read === 1'b0 &&
          sdram_writedata === 16'hCAFE && grant_id === 2'd2,
          64'({sdram_read, sdram_write, sdram_writedata, grant_id}),
          64'({1'b0, 1'b1, 16'hCAFE, 2'd2}));
    cl_read = 3'b000; cl_write = 3'b000;
    tick();
    check("rw_keep_rdata", cl_finished === 3'b100 && cl_readdata === 16'h5A5A,
          64'({cl_finished, cl_readdata}), 64'({3'b100, 16'h5A5A}));
    tick();

    // Reset in the middle of a read.
    cl_read = 3'b001;
    tick();
    cl_read = 3'b000;
    tick(); tick();
    i_rst = 1;
    tick();
    i_rst = 0;
    check("mid_rst", {busy, grant_id, cl_readdata, cl_finished, err_timeout,
                      sdram_read, sdram_write} === '0 && sdram_addr === '0,
          64'({busy, grant_id, cl_readdata, cl_finished, err_timeout, sdram_read, sdram_write}),
          64'h0);
    sdram_readdatavalid = 1; sdram_readdata = 16'hFFFF;
    held = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sdram_readdatavalid = 0;
      if (cl_finished !== 3'b000 || cl_readdata !== 16'h0) held++;
    end
    check("mid_rst_quiet", held == 0, 64'(held), 64'd0);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cl_read  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      cl_write = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      for (int i = 0; i < 3; i++) begin
        cl_addr[i]      = 23'($urandom);
        cl_writedata[i] = 16'($urandom);
      end
      sdram_waitrequest   = ($urandom_range(0, 9) < 3);
      sdram_readdatavalid = ($urandom_range(0, 9) < 2);
      sdram_readdata      = 16'($urandom);
      i_rst               = ($urandom_range(0, 599) == 0);
      tick();
    end
    clear_inputs();
    i_rst = 0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
